// File: rtl/tlb_pkg.sv
// Shared types and constants for the tlb_walker translation cache.
// The write-protect check is compiled in only when TLB_WP_EN is defined.
package tlb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUERY,
        S_LOAD_DIR,
        S_LOAD_ENT,
        S_INV,
        S_END
    } state_e;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_DIR  = 2'b01;
    localparam logic [1:0] FC_ENT  = 2'b10;
    localparam logic [1:0] FC_WP   = 2'b11;

    localparam int PTE_P = 0;
    localparam int PTE_W = 1;

    function automatic logic [1:0] ent_cause(
        input logic [31:0] pte,
        input logic        wr,
        input logic        wp_en
    );
        if (!pte[PTE_P]) return FC_ENT;
        if (wp_en && wr && !pte[PTE_W]) return FC_WP;
        return FC_NONE;
    endfunction

endpackage

// File: rtl/tlb_tag_array.sv
// Direct-mapped tag/data/valid store with one write port,
// tag-qualified invalidate and a flush that overrides everything.
module tlb_tag_array #(
    parameter int DEPTH = 64,
    parameter int TAG_W = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IW-1:0]    rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IW-1:0]    wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic             inv,
    input  logic [IW-1:0]    inv_idx,
    input  logic [TAG_W-1:0] inv_tag
);
    import tlb_pkg::*;

    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (inv && valid_q[inv_idx] && tag_mem[inv_idx] == inv_tag)
                valid_d[inv_idx] = 1'b0;
            if (we)
                valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (we && !flush) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/tlb_walker.sv
// Direct-mapped translation cache with a two-level page-table walker.
// Define TLB_WP_EN to enable the store write-protect fault (cause 11).
module tlb_walker
    import tlb_pkg::*;
#(
    parameter int DIR_DEPTH = 64,
    parameter int ENT_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic [31:0] v_addr_i,
    input  logic        v_lookup,
    input  logic        v_inv,
    input  logic        v_write_i,
    output logic [31:0] v_ent_o,
    output logic [19:0] v_page_o,
    output logic        v_ack_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr,
    output logic [1:0]  fault_cause
);
    localparam int DI  = $clog2(DIR_DEPTH);
    localparam int EI  = $clog2(ENT_DEPTH);
    localparam int DTW = (DI < 10) ? 10 - DI : 1;
    localparam int ETW = 20 - EI;

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic        write_q, write_d;
    logic [31:0] ent_q, ent_d;
    logic        pf_q, pf_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pfa_q, pfa_d;
    logic        rd_q, rd_d;
    logic [31:0] addr_q, addr_d;
    logic        stale_q, stale_d;

    logic           wp_en;
    logic [DI-1:0]  dir_idx;
    logic [DTW-1:0] dir_tag;
    logic [EI-1:0]  ent_idx;
    logic [ETW-1:0] ent_tag;
    logic           dir_hit, ent_hit;
    logic [31:0]    dir_rdata, ent_rdata;
    logic           dir_fill, ent_fill, inv_en, fill_ok;
    logic           cause_set;
    logic [1:0]     new_cause;

`ifdef TLB_WP_EN
    assign wp_en = 1'b1;
`else
    assign wp_en = 1'b0;
`endif

    assign dir_idx = vaddr_q[22 +: DI];
    assign dir_tag = DTW'(vaddr_q >> (22 + DI));
    assign ent_idx = vaddr_q[12 +: EI];
    assign ent_tag = ETW'(vaddr_q >> (12 + EI));

    // A flushed walk must not repopulate the caches with old-base data.
    assign fill_ok = !stale_q && !mmu_we;

    tlb_tag_array #(.DEPTH(DIR_DEPTH), .TAG_W(DTW)) u_dir (
        .clk     (clk),
        .rst     (rst),
        .flush   (mmu_we),
        .rd_idx  (dir_idx),
        .rd_tag  (dir_tag),
        .hit     (dir_hit),
        .rd_data (dir_rdata),
        .we      (dir_fill && fill_ok),
        .wr_idx  (dir_idx),
        .wr_tag  (dir_tag),
        .wr_data (data_i),
        .inv     (1'b0),
        .inv_idx (dir_idx),
        .inv_tag (dir_tag)
    );

    tlb_tag_array #(.DEPTH(ENT_DEPTH), .TAG_W(ETW)) u_ent (
        .clk     (clk),
        .rst     (rst),
        .flush   (mmu_we),
        .rd_idx  (ent_idx),
        .rd_tag  (ent_tag),
        .hit     (ent_hit),
        .rd_data (ent_rdata),
        .we      (ent_fill && fill_ok),
        .wr_idx  (ent_idx),
        .wr_tag  (ent_tag),
        .wr_data (data_i),
        .inv     (inv_en),
        .inv_idx (ent_idx),
        .inv_tag (ent_tag)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        vaddr_d   = vaddr_q;
        write_d   = write_q;
        ent_d     = ent_q;
        pf_d      = pf_q;
        cause_d   = cause_q;
        pfa_d     = pfa_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        stale_d   = stale_q;
        dir_fill  = 1'b0;
        ent_fill  = 1'b0;
        inv_en    = 1'b0;
        cause_set = 1'b0;
        new_cause = FC_NONE;

        unique case (state_q)
            S_IDLE: begin
                if (v_inv) begin
                    vaddr_d = v_addr_i;
                    state_d = S_INV;
                end else if (v_lookup) begin
                    vaddr_d = v_addr_i;
                    write_d = v_write_i;
                    pf_d    = 1'b0;
                    cause_d = FC_NONE;
                    pfa_d   = '0;
                    stale_d = 1'b0;
                    state_d = S_QUERY;
                end
            end
            S_QUERY: begin
                if (ent_hit) begin
                    ent_d     = ent_rdata;
                    cause_set = 1'b1;
                    new_cause = ent_cause(ent_rdata, write_q, wp_en);
                    state_d   = S_END;
                end else if (dir_hit && dir_rdata[PTE_P]) begin
                    rd_d    = 1'b1;
                    addr_d  = {dir_rdata[31:12], vaddr_q[21:12], 2'b00};
                    state_d = S_LOAD_ENT;
                end else if (dir_hit) begin
                    ent_d     = dir_rdata;
                    cause_set = 1'b1;
                    new_cause = FC_DIR;
                    state_d   = S_END;
                end else begin
                    rd_d    = 1'b1;
                    addr_d  = {base_q[31:12], vaddr_q[31:22], 2'b00};
                    state_d = S_LOAD_DIR;
                end
            end
            S_LOAD_DIR: begin
                if (ack_i) begin
                    dir_fill = 1'b1;
                    if (data_i[PTE_P]) begin
                        addr_d  = {data_i[31:12], vaddr_q[21:12], 2'b00};
                        state_d = S_LOAD_ENT;
                    end else begin
                        rd_d      = 1'b0;
                        ent_d     = data_i;
                        cause_set = 1'b1;
                        new_cause = FC_DIR;
                        state_d   = S_END;
                    end
                end
            end
            S_LOAD_ENT: begin
                if (ack_i) begin
                    ent_fill  = 1'b1;
                    rd_d      = 1'b0;
                    ent_d     = data_i;
                    cause_set = 1'b1;
                    new_cause = ent_cause(data_i, write_q, wp_en);
                    state_d   = S_END;
                end
            end
            S_INV: begin
                inv_en  = 1'b1;
                state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cause_set) begin
            cause_d = new_cause;
            pf_d    = (new_cause != FC_NONE);
            pfa_d   = (new_cause != FC_NONE) ? vaddr_q : '0;
        end

        if (mmu_we) begin
            base_d  = mmu_base_i;
            pf_d    = 1'b0;
            cause_d = FC_NONE;
            pfa_d   = '0;
            if (state_q == S_QUERY || state_q == S_LOAD_DIR ||
                state_q == S_LOAD_ENT)
                stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            vaddr_q <= '0;
            write_q <= 1'b0;
            ent_q   <= '0;
            pf_q    <= 1'b0;
            cause_q <= FC_NONE;
            pfa_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            vaddr_q <= vaddr_d;
            write_q <= write_d;
            ent_q   <= ent_d;
            pf_q    <= pf_d;
            cause_q <= cause_d;
            pfa_q   <= pfa_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            stale_q <= stale_d;
        end
    end

    assign mmu_base_o      = base_q;
    assign v_ent_o         = ent_q;
    assign v_page_o        = vaddr_q[31:12];
    assign v_ack_o         = (state_q == S_END);
    assign addr_o          = addr_q;
    assign rd_o            = rd_q;
    assign page_fault      = pf_q;
    assign page_fault_addr = pfa_q;
    assign fault_cause     = cause_q;

endmodule

// File: tb/tb_tlb_walker.sv
// Directed bench for tlb_walker with DIR_DEPTH=4, ENT_DEPTH=8 and
// a sparse word memory answering bus reads after a programmable wait.
module tb_tlb_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mmu_base_i = '0;
    logic        mmu_we = 1'b0;
    logic [31:0] mmu_base_o;
    logic [31:0] v_addr_i = '0;
    logic        v_lookup = 1'b0;
    logic        v_inv = 1'b0;
    logic        v_write_i = 1'b0;
    logic [31:0] v_ent_o;
    logic [19:0] v_page_o;
    logic        v_ack_o;
    logic [31:0] addr_o;
    logic [31:0] data_i = '0;
    logic        rd_o;
    logic        ack_i = 1'b0;
    logic        page_fault;
    logic [31:0] page_fault_addr;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    int waits  = 0;
    int reads  = 0;
    int wcnt   = 0;

    logic [31:0] mem [logic [31:0]];

    int          cyc;
    int          r0;
    logic [31:0] ent_s;
    logic        pf_s;
    logic [1:0]  fc_s;
    logic [31:0] pfa_s;
    logic [1:0]  wp_exp;

    tlb_walker #(.DIR_DEPTH(4), .ENT_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mmu_base_i      (mmu_base_i),
        .mmu_we          (mmu_we),
        .mmu_base_o      (mmu_base_o),
        .v_addr_i        (v_addr_i),
        .v_lookup        (v_lookup),
        .v_inv           (v_inv),
        .v_write_i       (v_write_i),
        .v_ent_o         (v_ent_o),
        .v_page_o        (v_page_o),
        .v_ack_o         (v_ack_o),
        .addr_o          (addr_o),
        .data_i          (data_i),
        .rd_o            (rd_o),
        .ack_i           (ack_i),
        .page_fault      (page_fault),
        .page_fault_addr (page_fault_addr),
        .fault_cause     (fault_cause)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_o && !rst) begin
            if (wcnt >= waits) begin
                ack_i  = 1'b1;
                data_i = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
                reads  = reads + 1;
                wcnt   = 0;
            end else begin
                ack_i = 1'b0;
                wcnt  = wcnt + 1;
            end
        end else begin
            ack_i = 1'b0;
            wcnt  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc = cycles from request (cycle 0) to the v_ack_o cycle, -1 on timeout.
    task automatic req(input logic [31:0] a, input logic wr,
                       input logic inv, input int we_cyc);
        @(negedge clk);
        v_addr_i  = a;
        v_write_i = wr;
        v_lookup  = !inv;
        v_inv     = inv;
        r0        = reads;
        @(posedge clk);
        cyc = 1;
        while (1) begin
            @(negedge clk);
            v_lookup = 1'b0;
            v_inv    = 1'b0;
            mmu_we   = (cyc == we_cyc);
            if (v_ack_o) break;
            if (cyc >= 200) begin
                cyc = -1;
                break;
            end
            cyc++;
        end
        mmu_we = 1'b0;
        ent_s  = v_ent_o;
        pf_s   = page_fault;
        fc_s   = fault_cause;
        pfa_s  = page_fault_addr;
    endtask

    initial begin
        mem[32'h0001_0004] = 32'h0002_0001;
        mem[32'h0002_0008] = 32'h0003_0001;
        mem[32'h0001_000C] = 32'h0004_0001;
        mem[32'h0004_0014] = 32'h0005_0003;
        mem[32'h0004_0018] = 32'h0006_0000;
        mem[32'h0002_000C] = 32'h0007_0001;
        mem[32'h0002_0028] = 32'h0008_0001;
        mem[32'h0001_0014] = 32'h0009_0001;
        mem[32'h0009_0000] = 32'h000A_0001;
        mem[32'h0002_0010] = 32'h000B_0001;
`ifdef TLB_WP_EN
        wp_exp = 2'b11;
`else
        wp_exp = 2'b00;
`endif

        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, v_ack_o}, 32'd0);
        chk("rst_rd", {31'b0, rd_o}, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_ent", v_ent_o, 32'd0);
        chk("rst_fault", {29'b0, page_fault, fault_cause}, 32'd0);
        chk("rst_pfa", page_fault_addr, 32'd0);
        chk("rst_base", mmu_base_o, 32'd0);
        rst = 1'b0;

        @(negedge clk);
        mmu_base_i = 32'h0001_0000;
        mmu_we     = 1'b1;
        @(negedge clk);
        mmu_we = 1'b0;
        chk("base_load", mmu_base_o, 32'h0001_0000);

        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("miss_cyc", cyc, 4);
        chk("miss_reads", reads - r0, 2);
        chk("miss_ent", ent_s, 32'h0003_0001);
        chk("miss_fault", {29'b0, pf_s, fc_s}, 32'd0);
        chk("miss_page", {12'b0, v_page_o}, 32'h0_0402);

        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("hit_cyc", cyc, 2);
        chk("hit_reads", reads - r0, 0);
        chk("hit_ent", ent_s, 32'h0003_0001);

        req(32'h0040_2123, 1'b1, 1'b0, -1);
        chk("wp_cyc", cyc, 2);
        chk("wp_cause", {30'b0, fc_s}, {30'b0, wp_exp});
        chk("wp_pf", {31'b0, pf_s}, {31'b0, wp_exp != 2'b00});

        req(32'h0040_2000, 1'b0, 1'b1, -1);
        chk("inv_cyc", cyc, 2);
        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("reinv_cyc", cyc, 3);
        chk("reinv_reads", reads - r0, 1);
        chk("reinv_ent", ent_s, 32'h0003_0001);
        chk("reinv_fault", {29'b0, pf_s, fc_s}, 32'd0);

        req(32'h0080_0000, 1'b0, 1'b0, -1);
        chk("dirf_cyc", cyc, 3);
        chk("dirf_cause", {29'b0, pf_s, fc_s}, 32'h5);
        chk("dirf_pfa", pfa_s, 32'h0080_0000);
        v_addr_i = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("dirf_hold_pfa", page_fault_addr, 32'h0080_0000);
        chk("dirf_hold_pf", {31'b0, page_fault}, 32'd1);

        waits = 2;
        req(32'h00C0_5000, 1'b0, 1'b0, -1);
        chk("wait_cyc", cyc, 8);
        chk("wait_reads", reads - r0, 2);
        chk("wait_ent", ent_s, 32'h0005_0003);
        chk("wait_fault", {29'b0, pf_s, fc_s}, 32'd0);

        req(32'h00C0_6000, 1'b0, 1'b0, -1);
        chk("entf_cyc", cyc, 5);
        chk("entf_reads", reads - r0, 1);
        chk("entf_cause", {29'b0, pf_s, fc_s}, 32'h6);
        chk("entf_pfa", pfa_s, 32'h00C0_6000);

        waits = 3;
        req(32'h0040_3000, 1'b0, 1'b0, 2);
        chk("stale_cyc", cyc, 6);
        chk("stale_reads", reads - r0, 1);
        chk("stale_ent", ent_s, 32'h0007_0001);
        waits = 0;
        req(32'h0040_3000, 1'b0, 1'b0, -1);
        chk("postwe_cyc", cyc, 4);
        chk("postwe_reads", reads - r0, 2);

        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("alias_a_reads", reads - r0, 1);
        req(32'h0040_A000, 1'b0, 1'b0, -1);
        chk("alias_b_reads", reads - r0, 1);
        chk("alias_b_ent", ent_s, 32'h0008_0001);
        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("alias_a2_reads", reads - r0, 1);
        chk("alias_a2_ent", ent_s, 32'h0003_0001);
        req(32'h0140_0000, 1'b0, 1'b0, -1);
        chk("dalias_reads", reads - r0, 2);
        chk("dalias_ent", ent_s, 32'h000A_0001);
        req(32'h0040_2123, 1'b0, 1'b0, -1);
        chk("dalias_ehit_reads", reads - r0, 0);
        req(32'h0040_4000, 1'b0, 1'b0, -1);
        chk("dalias_evict_reads", reads - r0, 2);
        chk("dalias_evict_ent", ent_s, 32'h000B_0001);

        waits = 20;
        @(negedge clk);
        v_addr_i = 32'h0100_0000;
        v_lookup = 1'b1;
        @(negedge clk);
        v_lookup = 1'b0;
        @(negedge clk);
        chk("midwalk_rd", {31'b0, rd_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwalk_rd", {31'b0, rd_o}, 32'd0);
        chk("rstwalk_base", mmu_base_o, 32'd0);
        rst   = 1'b0;
        waits = 0;
        @(negedge clk);
        chk("rstwalk_ack", {31'b0, v_ack_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
